approx_add_sched: RTL and testbench
===================================

APPROX_ADD_SCHED -- requirements
Module: approx_add_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder (2..8).
REQ-002 Parameter WIDTH, default 8: operand width; result is WIDTH+1 bits.
REQ-003 Parameter MAX_APPROX, default 4: upper limit on approximate LSB count.
REQ-004 clock  in  1  single clock; all state on posedge clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_x  in  NREQ*WIDTH  packed X operands; requester i at [i*WIDTH +: WIDTH].
REQ-008 req_y  in  NREQ*WIDTH  packed Y operands; same packing.
REQ-009 req_exact  in  NREQ  per-requester override; 1 forces an exact add.
REQ-010 req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
REQ-011 cfg_approx_lsbs  in  3  global approximate LSB count k.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  consumer accepts result.
REQ-014 rsp_id  out  $clog2(NREQ)  index of the requester that owns the result.
REQ-015 rsp_sum  out  WIDTH+1  result; bit WIDTH is the carry out.
REQ-016 op_count  out  16  count of completed responses; saturates at 0xFFFF.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, CALC, HOLD.
REQ-018 IDLE: if any req_valid is high, the block SHALL grant one requester round-robin, starting at (last_grant+1) mod NREQ, and assert only that requester's req_ready in the same cycle.
REQ-019 On grant, the block SHALL capture X, Y, the requester id, and k_eff = 0 if req_exact, else min(cfg_approx_lsbs, MAX_APPROX); it SHALL then update last_grant and go to CALC.
REQ-020 req_ready SHALL be 0 in CALC and HOLD, and in IDLE when no req_valid is high.
REQ-021 CALC: the block SHALL register the core result into rsp_sum and rsp_id, set rsp_valid=1, and go to HOLD; latency is grant edge + 2 cycles to rsp_valid.
REQ-022 HOLD: rsp_sum, rsp_id and rsp_valid SHALL stay stable until rsp_ready=1. On that edge it SHALL clear rsp_valid, increment op_count (saturating) and return to IDLE.
REQ-023 Arithmetic for bit i < k_eff: S[i]=Y[i], carry_out[i]=X[i]. Carry into bit k_eff is X[k_eff-1], or 0 when k_eff=0.
REQ-024 Arithmetic for bits i >= k_eff: exact ripple full-add. S[WIDTH] is the final carry; there is no external carry in.
REQ-025 A change of cfg_approx_lsbs after grant SHALL NOT affect the operation in flight.
REQ-026 Inputs from requesters not granted SHALL be ignored; those requesters keep req_valid high until granted.
REQ-027 If no request arrives, the FSM SHALL stay in IDLE with all outputs held.

Reset
REQ-028 rst_n low SHALL immediately force: state=IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, op_count=0, and last_grant=NREQ-1 so that requester 0 wins first.
REQ-029 Reset during CALC or HOLD SHALL discard the operation in flight without producing a response.

Structure
REQ-030 Package approx_pkg SHALL hold the state enum, the default NREQ, WIDTH and MAX_APPROX, and the op_count width constant.
REQ-031 The datapath SHALL be one combinational sub-module, approx_add_core (inputs X, Y, k; output S[WIDTH:0]), instantiated once.

Verification
REQ-032 k=4, requester 0: X=0x0F, Y=0x01 -> rsp_sum=0x011, rsp_id=0, rsp_valid exactly 2 cycles after grant.
REQ-033 Same operands with req_exact[0]=1 -> rsp_sum=0x010; k=4, X=0xFF, Y=0xFF -> 0x1FF; exact -> 0x1FE.
REQ-034 All four requesters valid continuously after reset -> grants in order 0,1,2,3,0; each req_ready pulse lasts one cycle; op_count=5 after five accepted responses.
REQ-035 rsp_ready held 0 for 10 cycles -> rsp_sum and rsp_id stay stable, req_ready stays 0, op_count is unchanged; rsp_ready=1 -> FSM returns to IDLE next cycle.
REQ-036 cfg_approx_lsbs=7 -> behaves as k=4. cfg changed from 4 to 0 in CALC -> result still computed with k=4.
REQ-037 rst_n asserted in HOLD -> all outputs are zero immediately; after release, requester 0 wins the first grant and no stale response appears.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared defaults and FSM encoding for the approximate-adder scheduler.
package approx_pkg;
  localparam int NREQ_DEF       = 4;
  localparam int WIDTH_DEF      = 8;
  localparam int MAX_APPROX_DEF = 4;
  localparam int OPCNT_W        = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/approx_add_core.sv
// Lower-part-OR style approximate adder: the low k bits pass Y through and
// forward X as carry; the remaining bits ripple exactly.
module approx_add_core #(
  parameter int WIDTH = 8,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH:0]   o_s
);
  logic w_c;

  always_comb begin
    o_s = '0;
    w_c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(i_k)) begin
        o_s[i] = i_y[i];
        w_c    = i_x[i];
      end else begin
        o_s[i] = i_x[i] ^ i_y[i] ^ w_c;
        w_c    = (i_x[i] & i_y[i]) | (w_c & (i_x[i] ^ i_y[i]));
      end
    end
    o_s[WIDTH] = w_c;
  end
endmodule

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one approximate adder among NREQ requesters;
// one operation in flight at a time, result held until the consumer accepts.
module approx_add_sched
  import approx_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_APPROX = MAX_APPROX_DEF,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ-1:0]       req_exact,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2:0]            cfg_approx_lsbs,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH:0]        rsp_sum,
  output logic [OPCNT_W-1:0]    op_count
);
  localparam logic [2:0] KMAX = 3'(MAX_APPROX);

  state_t               r_state;
  logic [IDW-1:0]       r_last;
  logic [IDW-1:0]       r_id;
  logic [WIDTH-1:0]     r_x;
  logic [WIDTH-1:0]     r_y;
  logic [2:0]           r_k;
  logic                 r_rsp_valid;
  logic [IDW-1:0]       r_rsp_id;
  logic [WIDTH:0]       r_rsp_sum;
  logic [OPCNT_W-1:0]   r_cnt;

  logic                 w_any;
  logic [IDW-1:0]       w_gnt;
  logic [WIDTH-1:0]     w_x;
  logic [WIDTH-1:0]     w_y;
  logic [2:0]           w_k_eff;
  logic [WIDTH:0]       w_sum;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_gnt = r_last;
    for (int o = 1; o <= NREQ; o++) begin
      idx = (int'(r_last) + o) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = IDW'(idx);
      end
    end
  end

  assign w_x     = req_x[w_gnt*WIDTH +: WIDTH];
  assign w_y     = req_y[w_gnt*WIDTH +: WIDTH];
  assign w_k_eff = req_exact[w_gnt] ? 3'd0 :
                   (cfg_approx_lsbs > KMAX) ? KMAX : cfg_approx_lsbs;

  // Gated by rst_n so the grant drops the moment reset asserts.
  assign req_ready = (rst_n && r_state == S_IDLE && w_any) ?
                     (NREQ'(1) << w_gnt) : '0;

  approx_add_core #(.WIDTH(WIDTH), .KW(3)) u_core (
    .i_x (r_x),
    .i_y (r_y),
    .i_k (r_k),
    .o_s (w_sum)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_x     <= w_x;
          r_y     <= w_y;
          r_k     <= w_k_eff;
          r_id    <= w_gnt;
          r_last  <= w_gnt;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_rsp_sum   <= w_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign op_count  = r_cnt;
endmodule

// File: tb/tb_approx_add_sched.sv
// Directed + random bench for approx_add_sched with a response scoreboard.
module tb_approx_add_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clock = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_x = '0;
  logic [NREQ*WIDTH-1:0] req_y = '0;
  logic [NREQ-1:0]       req_exact = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2:0]            cfg_approx_lsbs = 3'd0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [1:0]            rsp_id;
  logic [WIDTH:0]        rsp_sum;
  logic [15:0]           op_count;

  typedef struct {
    logic [1:0] id;
    logic [8:0] sum;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  always #5 clock = ~clock;

  approx_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_APPROX(4)) dut (
    .clock           (clock),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_x           (req_x),
    .req_y           (req_y),
    .req_exact       (req_exact),
    .req_ready       (req_ready),
    .cfg_approx_lsbs (cfg_approx_lsbs),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_sum         (rsp_sum),
    .op_count        (op_count)
  );

  // Arithmetic reference: exact add of the upper parts plus injected carry.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ex, input logic [2:0] cfg);
    int k, xi, yi, cin, hi;
    k   = ex ? 0 : ((int'(cfg) > 4) ? 4 : int'(cfg));
    xi  = int'(x);
    yi  = int'(y);
    cin = (k == 0) ? 0 : ((xi >> (k - 1)) & 1);
    hi  = (xi >> k) + (yi >> k) + cin;
    return 9'(((hi << k) | (yi & ((1 << k) - 1))) & 32'h1FF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int id, input logic [7:0] x, input logic [7:0] y, input logic ex);
    req_x[id*WIDTH +: WIDTH] = x;
    req_y[id*WIDTH +: WIDTH] = y;
    req_exact[id]            = ex;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(rsp_sum), 32'(e.sum));
      chk({tag, "_id"},  32'(rsp_id),  32'(e.id));
    end
  endtask

  // One isolated operation with rsp_ready high; cfg may change after grant.
  task automatic run_op(input int id, input logic [7:0] x, input logic [7:0] y,
                        input logic ex, input logic [2:0] cfg, input logic [2:0] cfg_after);
    @(negedge clock);
    put(id, x, y, ex);
    req_valid       = NREQ'(1) << id;
    cfg_approx_lsbs = cfg;
    #1;
    chk("grant", 32'(req_ready), 32'(1) << id);
    sb.push_back('{2'(id), model(x, y, ex, cfg)});
    @(posedge clock);
    #1;
    req_valid       = '0;
    cfg_approx_lsbs = cfg_after;
    @(negedge clock);
    chk("calc_vld", 32'(rsp_valid), 32'd0);
    chk("calc_rdy", 32'(req_ready), 32'd0);
    @(negedge clock);
    chk("rsp_vld", 32'(rsp_valid), 32'd1);
    pop_chk("op");
    exp_cnt++;
    @(negedge clock);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    exp_t        held;
    logic [7:0]  rx [NREQ];
    logic [7:0]  ry [NREQ];
    logic [7:0]  a, b;
    logic [2:0]  c;
    logic        ex;
    int          id;
    int          n;

    // Reset with every requester asserting: grant must stay low.
    req_valid = '1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sum",   32'(rsp_sum),   32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_cnt",   32'(op_count),  32'd0);
    @(negedge clock);
    req_valid = '0;
    @(negedge clock);
    rst_n = 1'b1;

    // No requests: nothing moves.
    repeat (3) begin
      @(negedge clock);
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_valid", 32'(rsp_valid), 32'd0);
      chk("idle_cnt",   32'(op_count),  32'd0);
    end

    // Directed arithmetic cases.
    run_op(0, 8'h0F, 8'h01, 1'b0, 3'd4, 3'd4);
    run_op(0, 8'h0F, 8'h01, 1'b1, 3'd4, 3'd4);
    run_op(1, 8'hFF, 8'hFF, 1'b0, 3'd4, 3'd4);
    run_op(2, 8'hFF, 8'hFF, 1'b1, 3'd4, 3'd4);
    run_op(3, 8'h0F, 8'h01, 1'b0, 3'd7, 3'd7);
    run_op(1, 8'h0F, 8'h01, 1'b0, 3'd4, 3'd0);
    run_op(2, 8'h03, 8'h00, 1'b0, 3'd2, 3'd2);

    for (int r = 0; r < 8; r++) begin
      id = int'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      ex = 1'($urandom_range(0, 1));
      c  = 3'($urandom_range(0, 7));
      run_op(id, a, b, ex, c, c);
    end

    // Back-pressure: response frozen, another requester waits.
    @(negedge clock);
    put(0, 8'h12, 8'h34, 1'b0);
    req_valid       = 4'b0001;
    cfg_approx_lsbs = 3'd3;
    rsp_ready       = 1'b0;
    #1;
    chk("hold_grant", 32'(req_ready), 32'd1);
    sb.push_back('{2'd0, model(8'h12, 8'h34, 1'b0, 3'd3)});
    @(posedge clock);
    #1 req_valid = 4'b0010;
    @(negedge clock);
    chk("hold_calc", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk("hold_vld", 32'(rsp_valid), 32'd1);
    held = sb[0];
    pop_chk("hold");
    repeat (10) begin
      @(negedge clock);
      chk("hold_vld_stable", 32'(rsp_valid), 32'd1);
      chk("hold_sum_stable", 32'(rsp_sum),   32'(held.sum));
      chk("hold_id_stable",  32'(rsp_id),    32'(held.id));
      chk("hold_ready_low",  32'(req_ready), 32'd0);
      chk("hold_cnt_stable", 32'(op_count),  32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    exp_cnt++;
    chk("release_vld",   32'(rsp_valid), 32'd0);
    chk("release_ready", 32'(req_ready), 32'b0010);
    chk("release_cnt",   32'(op_count),  32'(exp_cnt));
    req_valid = '0;

    // Reset while holding a result for requester 2.
    @(negedge clock);
    put(2, 8'hA5, 8'h5A, 1'b0);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    chk("rh_grant", 32'(req_ready), 32'b0100);
    @(posedge clock);
    #1 req_valid = '1;
    @(negedge clock);
    @(negedge clock);
    chk("rh_vld", 32'(rsp_valid), 32'd1);
    chk("rh_id",  32'(rsp_id),    32'd2);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rh_rst_vld",   32'(rsp_valid), 32'd0);
    chk("rh_rst_sum",   32'(rsp_sum),   32'd0);
    chk("rh_rst_id",    32'(rsp_id),    32'd0);
    chk("rh_rst_cnt",   32'(op_count),  32'd0);
    chk("rh_rst_ready", 32'(req_ready), 32'd0);

    // Release with all four requesting: rotation 0,1,2,3,0.
    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      rx[i] = 8'(8'h11 * (i + 1));
      ry[i] = 8'(8'hF0 - 8'h07 * i);
      put(i, rx[i], ry[i], 1'b0);
    end
    cfg_approx_lsbs = 3'd0;
    rsp_ready       = 1'b1;
    rst_n           = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 8) begin
        @(negedge clock);
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(1) << (g % 4));
      sb.push_back('{2'(g % 4), model(rx[g % 4], ry[g % 4], 1'b0, 3'd0)});
      @(negedge clock);
      chk("rr_pulse", 32'(req_ready), 32'd0);
      chk("rr_calc",  32'(rsp_valid), 32'd0);
      @(negedge clock);
      chk("rr_vld", 32'(rsp_valid), 32'd1);
      pop_chk("rr");
      exp_cnt++;
      if (g == 4) req_valid = '0;
    end
    @(negedge clock);
    chk("rr_cnt",   32'(op_count),  32'd5);
    chk("rr_model", 32'(op_count),  32'(exp_cnt));
    chk("rr_idle",  32'(req_ready), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
